// File: rtl/pac_pkg.sv
// Shared constants and types for the Pac-Man movement controller:
// one-hot directions, FSM encoding and the candidate-position record.
package pac_pkg;

   localparam int COORD_W = 32;

   localparam logic [3:0] DIR_UP    = 4'b0001;
   localparam logic [3:0] DIR_LEFT  = 4'b0010;
   localparam logic [3:0] DIR_DOWN  = 4'b0100;
   localparam logic [3:0] DIR_RIGHT = 4'b1000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHOOSE,
      ST_PROBE_REQ,
      ST_PROBE_CUR,
      ST_MOVE,
      ST_STOP
   } state_t;

   typedef struct packed {
      logic               out_of_range;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } cand_t;

endpackage

// File: rtl/pac_btn_latch.sv
// Two-flop synchroniser for the four raw buttons followed by a sticky
// request register that the movement FSM clears once it has consumed it.
module pac_btn_latch
   import pac_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] btn,
   input  logic       clear,
   output logic [3:0] req
);

   logic [3:0] sync1;
   logic [3:0] sync2;

   // A level still high during the clear cycle re-arms its bit immediately,
   // so a press coinciding with the clear is kept for the next evaluation.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         req   <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         req   <= clear ? sync2 : (req | sync2);
      end
   end

endmodule

// File: rtl/pac_motion.sv
// Pac-Man movement controller: frame divider, direction choice, maze-map
// probe handshake with tunnel wrap, and registered position/heading outputs.
module pac_motion
   import pac_pkg::*;
#(
   parameter int X_MIN    = 32,
   parameter int X_MAX    = 600,
   parameter int Y_MIN    = 32,
   parameter int Y_MAX    = 440,
   parameter int START_X  = 320,
   parameter int START_Y  = 240,
   parameter int STEP     = 4,
   parameter int MOVE_DIV = 2
)
(
   input  logic               clock,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               btn_up,
   input  logic               btn_left,
   input  logic               btn_down,
   input  logic               btn_right,
   output logic               probe_valid,
   output logic [COORD_W-1:0] probe_x,
   output logic [COORD_W-1:0] probe_y,
   input  logic               probe_done,
   input  logic               probe_blocked,
   output logic [COORD_W-1:0] pos1,
   output logic [COORD_W-1:0] pos2,
   output logic               up,
   output logic               left,
   output logic               down,
   output logic               right,
   output logic               moving,
   output logic               mouth_open
);

   localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
   localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(MOVE_DIV - 1);
   localparam logic [COORD_W-1:0] X_MIN_C   = COORD_W'(X_MIN);
   localparam logic [COORD_W-1:0] X_MAX_C   = COORD_W'(X_MAX);
   localparam logic [COORD_W-1:0] Y_MIN_C   = COORD_W'(Y_MIN);
   localparam logic [COORD_W-1:0] Y_MAX_C   = COORD_W'(Y_MAX);
   localparam logic [COORD_W-1:0] STEP_C    = COORD_W'(STEP);
   localparam logic [COORD_W-1:0] START_X_C = COORD_W'(START_X);
   localparam logic [COORD_W-1:0] START_Y_C = COORD_W'(START_Y);

   state_t           state;
   logic [DIV_W-1:0] div_cnt;
   logic [3:0]       heading;
   logic [3:0]       move_dir;
   logic [3:0]       req;
   logic [3:0]       req_dir;
   cand_t            cand_req;
   cand_t            cand_cur;

   pac_btn_latch u_btn (
      .clock (clock),
      .reset (reset),
      .btn   ({btn_right, btn_down, btn_left, btn_up}),
      .clear (state == ST_CHOOSE),
      .req   (req)
   );

   // Horizontal moves wrap through the tunnel; vertical moves past the
   // playfield edge are refused here and never reach the map.
   function automatic cand_t step_from(input logic [3:0] dir,
                                       input logic [COORD_W-1:0] x,
                                       input logic [COORD_W-1:0] y);
      cand_t c;
      c.out_of_range = 1'b0;
      c.x = x;
      c.y = y;
      case (dir)
         DIR_UP:    if (y < Y_MIN_C + STEP_C) c.out_of_range = 1'b1;
                    else c.y = y - STEP_C;
         DIR_DOWN:  if (y + STEP_C > Y_MAX_C) c.out_of_range = 1'b1;
                    else c.y = y + STEP_C;
         DIR_LEFT:  c.x = (x < X_MIN_C + STEP_C) ? X_MAX_C : x - STEP_C;
         DIR_RIGHT: c.x = (x + STEP_C > X_MAX_C) ? X_MIN_C : x + STEP_C;
         default:   c.out_of_range = 1'b1;
      endcase
      return c;
   endfunction

   always_comb begin
      req_dir = heading;
      if (req[0])      req_dir = DIR_UP;
      else if (req[1]) req_dir = DIR_LEFT;
      else if (req[2]) req_dir = DIR_DOWN;
      else if (req[3]) req_dir = DIR_RIGHT;
      cand_req = step_from(req_dir, pos1, pos2);
      cand_cur = step_from(heading, pos1, pos2);
   end

   // probe_x/probe_y double as the pending step target, so MOVE copies
   // them straight into the position; PROBE_CUR re-raises valid after a gap.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         div_cnt     <= '0;
         probe_valid <= 1'b0;
         probe_x     <= '0;
         probe_y     <= '0;
         pos1        <= START_X_C;
         pos2        <= START_Y_C;
         heading     <= DIR_RIGHT;
         move_dir    <= DIR_RIGHT;
         moving      <= 1'b0;
         mouth_open  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (frame_tick) begin
                  if (div_cnt == DIV_LAST) begin
                     div_cnt <= '0;
                     state   <= ST_CHOOSE;
                  end else begin
                     div_cnt <= div_cnt + 1'b1;
                  end
               end
            end
            ST_CHOOSE: begin
               if (!cand_req.out_of_range) begin
                  probe_x     <= cand_req.x;
                  probe_y     <= cand_req.y;
                  probe_valid <= 1'b1;
                  move_dir    <= req_dir;
                  state       <= ST_PROBE_REQ;
               end else if (req_dir != heading && !cand_cur.out_of_range) begin
                  probe_x     <= cand_cur.x;
                  probe_y     <= cand_cur.y;
                  probe_valid <= 1'b1;
                  move_dir    <= heading;
                  state       <= ST_PROBE_CUR;
               end else begin
                  state <= ST_STOP;
               end
            end
            ST_PROBE_REQ: begin
               if (probe_done) begin
                  probe_valid <= 1'b0;
                  if (!probe_blocked) begin
                     state <= ST_MOVE;
                  end else if (move_dir != heading && !cand_cur.out_of_range) begin
                     probe_x  <= cand_cur.x;
                     probe_y  <= cand_cur.y;
                     move_dir <= heading;
                     state    <= ST_PROBE_CUR;
                  end else begin
                     state <= ST_STOP;
                  end
               end
            end
            ST_PROBE_CUR: begin
               if (!probe_valid) begin
                  probe_valid <= 1'b1;
               end else if (probe_done) begin
                  probe_valid <= 1'b0;
                  state       <= probe_blocked ? ST_STOP : ST_MOVE;
               end
            end
            ST_MOVE: begin
               pos1       <= probe_x;
               pos2       <= probe_y;
               heading    <= move_dir;
               moving     <= 1'b1;
               mouth_open <= ~mouth_open;
               state      <= ST_IDLE;
            end
            ST_STOP: begin
               moving <= 1'b0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign up    = heading[0];
   assign left  = heading[1];
   assign down  = heading[2];
   assign right = heading[3];

endmodule

// File: tb/tb_pac_motion.sv
// Scoreboard bench for pac_motion: stimulus queues expected probes and
// status changes, a negedge monitor pops and compares them as the DUT reacts.
module tb_pac_motion;

   localparam logic [3:0] H_U = 4'b0001;
   localparam logic [3:0] H_L = 4'b0010;
   localparam logic [3:0] H_R = 4'b1000;

   typedef logic [127:0] tag_t;
   typedef struct packed {
      tag_t        name;
      logic [31:0] x;
      logic [31:0] y;
   } probe_exp_t;
   typedef struct packed {
      tag_t        name;
      logic [31:0] x;
      logic [31:0] y;
      logic [3:0]  hd;
      logic        mv;
      logic        mo;
      logic        pv;
      logic [31:0] px;
      logic [31:0] py;
   } snap_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        frame_tick = 1'b0;
   logic        btn_up = 1'b0, btn_left = 1'b0, btn_down = 1'b0, btn_right = 1'b0;
   logic        probe_valid, probe_done, probe_blocked;
   logic [31:0] probe_x, probe_y, pos1, pos2;
   logic        up, left, down, right, moving, mouth_open;
   logic        map_en = 1'b1, block_en = 1'b0;
   logic [31:0] block_x = '0, block_y = '0;

   probe_exp_t  probe_q[$];
   snap_t       state_q[$];
   snap_t       snap_q[$];
   int          checks = 0;
   int          failures = 0;
   logic        done_flag = 1'b0;
   logic        mon_done = 1'b0;

   logic [31:0] ex = 320, ey = 240;
   logic [3:0]  ehd = H_R;
   logic        emv = 1'b0, emo = 1'b0;

   always #5 clock = ~clock;

   // Combinational map: answers any probe at once unless stalled, with one
   // configurable wall cell.
   assign probe_done    = probe_valid && map_en;
   assign probe_blocked = block_en && (probe_x == block_x) && (probe_y == block_y);

   pac_motion #(.MOVE_DIV(2)) dut (
      .clock(clock), .reset(reset), .frame_tick(frame_tick),
      .btn_up(btn_up), .btn_left(btn_left), .btn_down(btn_down), .btn_right(btn_right),
      .probe_valid(probe_valid), .probe_x(probe_x), .probe_y(probe_y),
      .probe_done(probe_done), .probe_blocked(probe_blocked),
      .pos1(pos1), .pos2(pos2), .up(up), .left(left), .down(down), .right(right),
      .moving(moving), .mouth_open(mouth_open)
   );

   logic [3:0]  cur_hd;
   logic [69:0] status, prev_status;
   logic        prev_pv;
   assign cur_hd = {right, down, left, up};
   assign status = {pos1, pos2, cur_hd, moving, mouth_open};

   task automatic check_output(input snap_t e, input logic with_probe);
      logic bad;
      checks++;
      bad = (status !== {e.x, e.y, e.hd, e.mv, e.mo});
      if (with_probe && (probe_valid !== e.pv || (e.pv && {probe_x, probe_y} !== {e.px, e.py})))
         bad = 1'b1;
      if (bad) begin
         failures++;
         $display("[TB] FAIL %0s: got pos=(%0d,%0d) hd=%b mv=%b mo=%b pv=%b probe=(%0d,%0d) want pos=(%0d,%0d) hd=%b mv=%b mo=%b pv=%b probe=(%0d,%0d)",
                  e.name, pos1, pos2, cur_hd, moving, mouth_open, probe_valid, probe_x, probe_y,
                  e.x, e.y, e.hd, e.mv, e.mo, e.pv, e.px, e.py);
      end
   endtask

   task automatic check_probe(input probe_exp_t e);
      checks++;
      if ({probe_x, probe_y} !== {e.x, e.y}) begin
         failures++;
         $display("[TB] FAIL probe %0s: got (%0d,%0d) want (%0d,%0d)", e.name, probe_x, probe_y, e.x, e.y);
      end
   endtask

   always @(negedge clock) begin
      if (snap_q.size() != 0) check_output(snap_q.pop_front(), 1'b1);
      if (reset) begin
         prev_pv     <= 1'b0;
         prev_status <= status;
      end else begin
         if (probe_valid && !prev_pv) begin
            if (probe_q.size() == 0) begin
               checks++; failures++;
               $display("[TB] FAIL probe unexpected: got (%0d,%0d) want none", probe_x, probe_y);
            end else begin
               check_probe(probe_q.pop_front());
            end
         end
         if (status !== prev_status) begin
            if (state_q.size() == 0) begin
               checks++; failures++;
               $display("[TB] FAIL status unexpected: got pos=(%0d,%0d) hd=%b mv=%b mo=%b want no change",
                        pos1, pos2, cur_hd, moving, mouth_open);
            end else begin
               check_output(state_q.pop_front(), 1'b0);
            end
         end
         prev_pv     <= probe_valid;
         prev_status <= status;
      end
      if (done_flag && !mon_done) begin
         checks += 2;
         if (probe_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL probes_outstanding: got %0d want 0", probe_q.size());
         end
         if (state_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL status_outstanding: got %0d want 0", state_q.size());
         end
         mon_done <= 1'b1;
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse_tick();
      @(negedge clock) frame_tick = 1'b1;
      @(negedge clock) frame_tick = 1'b0;
   endtask

   // One evaluation: two frame ticks satisfy the divider of 2.
   task automatic apply_stimulus();
      pulse_tick();
      wait_cycles(3);
      pulse_tick();
      wait_cycles(10);
   endtask

   task automatic press_btn(input logic [3:0] b);
      @(negedge clock) {btn_right, btn_down, btn_left, btn_up} = b;
      wait_cycles(2);
      {btn_right, btn_down, btn_left, btn_up} = 4'b0000;
      wait_cycles(2);
   endtask

   task automatic push_probe(input tag_t name, input logic [31:0] x, input logic [31:0] y);
      probe_q.push_back('{name: name, x: x, y: y});
   endtask

   task automatic expect_move(input tag_t name, input logic [31:0] nx, input logic [31:0] ny,
                              input logic [3:0] nhd);
      push_probe(name, nx, ny);
      ex = nx; ey = ny; ehd = nhd; emv = 1'b1; emo = ~emo;
      state_q.push_back('{name: name, x: ex, y: ey, hd: ehd, mv: 1'b1, mo: emo,
                          pv: 1'b0, px: '0, py: '0});
   endtask

   task automatic expect_stop(input tag_t name);
      emv = 1'b0;
      state_q.push_back('{name: name, x: ex, y: ey, hd: ehd, mv: 1'b0, mo: emo,
                          pv: 1'b0, px: '0, py: '0});
   endtask

   task automatic push_snap(input tag_t name, input logic [31:0] x, input logic [31:0] y,
                            input logic [3:0] hd, input logic mv, input logic mo,
                            input logic pv, input logic [31:0] px, input logic [31:0] py);
      @(posedge clock);
      #1;
      snap_q.push_back('{name: name, x: x, y: y, hd: hd, mv: mv, mo: mo, pv: pv, px: px, py: py});
      @(negedge clock);
      #1;
   endtask

   initial begin
      logic [31:0] sx, sy;
      logic        smo;

      wait_cycles(3);
      push_snap("reset_state", 320, 240, H_R, 1'b0, 1'b0, 1'b0, 0, 0);
      @(negedge clock) reset = 1'b0;
      wait_cycles(3);

      pulse_tick();
      wait_cycles(6);
      push_snap("div_single_tick", 320, 240, H_R, 1'b0, 1'b0, 1'b0, 0, 0);
      expect_move("right_first", 324, 240, H_R);
      pulse_tick();
      wait_cycles(10);

      press_btn(H_U);
      expect_move("btn_up", 324, 236, H_U);
      apply_stimulus();

      press_btn(H_R);
      expect_move("back_right", 328, 236, H_R);
      apply_stimulus();

      block_x = 328; block_y = 232; block_en = 1'b1;
      press_btn(H_U);
      push_probe("up_blocked", 328, 232);
      expect_move("fallback_right", 332, 236, H_R);
      apply_stimulus();

      block_x = 336; block_y = 236;
      push_probe("ahead_blocked", 336, 236);
      expect_stop("ahead_stop");
      apply_stimulus();
      block_en = 1'b0;

      while (ex < 600) begin
         expect_move("run_right", ex + 4, ey, H_R);
         apply_stimulus();
      end
      expect_move("wrap_right", 32, 236, H_R);
      apply_stimulus();
      press_btn(H_L);
      expect_move("wrap_left", 600, 236, H_L);
      apply_stimulus();

      @(negedge clock) btn_up = 1'b1;
      wait_cycles(3);
      while (ey > 32) begin
         expect_move("run_up", ex, ey - 4, H_U);
         apply_stimulus();
      end
      btn_up = 1'b0;
      wait_cycles(3);
      expect_stop("top_stop");
      apply_stimulus();

      press_btn(H_R);
      expect_move("wrap_right_top", 32, 32, H_R);
      apply_stimulus();
      @(negedge clock) btn_up = 1'b1;
      wait_cycles(3);
      expect_move("up_oob_cur", 36, 32, H_R);
      apply_stimulus();
      btn_up = 1'b0;
      wait_cycles(3);

      map_en = 1'b0;
      sx = ex; sy = ey; smo = emo;
      expect_move("stall_move", 40, 32, H_R);
      pulse_tick();
      wait_cycles(3);
      pulse_tick();
      wait_cycles(4);
      push_snap("stall_early", sx, sy, H_R, 1'b1, smo, 1'b1, 40, 32);
      pulse_tick();
      wait_cycles(6);
      push_snap("stall_late", sx, sy, H_R, 1'b1, smo, 1'b1, 40, 32);
      map_en = 1'b1;
      wait_cycles(6);
      pulse_tick();
      wait_cycles(6);
      push_snap("tick_dropped", 40, 32, H_R, 1'b1, emo, 1'b0, 0, 0);
      expect_move("after_stall", 44, 32, H_R);
      pulse_tick();
      wait_cycles(10);

      map_en = 1'b0;
      push_probe("pre_reset", 48, 32);
      pulse_tick();
      wait_cycles(3);
      pulse_tick();
      wait_cycles(4);
      @(negedge clock) reset = 1'b1;
      ex = 320; ey = 240; ehd = H_R; emv = 1'b0; emo = 1'b0;
      wait_cycles(2);
      push_snap("reset_mid_probe", 320, 240, H_R, 1'b0, 1'b0, 1'b0, 0, 0);
      @(negedge clock) reset = 1'b0;
      map_en = 1'b1;
      wait_cycles(3);
      expect_move("post_reset", 324, 240, H_R);
      apply_stimulus();

      done_flag = 1'b1;
      wait_cycles(4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got no completion want finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
